// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: a one-entry output register is
// refilled from RAM ahead of writes, and bypassed directly when the RAM is empty.
module sp_ram_fifo_ctrl #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;

    logic pop;
    logic ob_free;
    logic ram_nonempty;
    logic rd_op;
    logic accept;
    logic bypass;
    logic wr_op;

    assign pop          = out_valid & out_ready;
    assign ob_free      = ~out_valid | pop;
    assign ram_nonempty = (ram_cnt != '0);

    // Refilling the output register wins the RAM port; the producer stalls that cycle.
    assign rd_op    = ob_free & ram_nonempty;
    assign in_ready = rst & ~rd_op & (ram_cnt != CNT_DEPTH);
    assign accept   = in_valid & in_ready;

    // Bypass only when nothing is queued in RAM, so ordering is preserved.
    assign bypass = accept & ob_free & ~ram_nonempty;
    assign wr_op  = accept & ~bypass;

    assign ram_wr   = wr_op;
    assign ram_addr = wr_op ? wr_ptr : rd_ptr;
    assign ram_din  = in_data;

    assign count = ram_cnt + (AW+1)'(out_valid);
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_op) begin
                wr_ptr  <= wr_ptr + AW'(1);
                ram_cnt <= ram_cnt + (AW+1)'(1);
            end else if (rd_op) begin
                rd_ptr  <= rd_ptr + AW'(1);
                ram_cnt <= ram_cnt - (AW+1)'(1);
            end
            if (rd_op) begin
                out_data <= ram_dout;
            end else if (bypass) begin
                out_data <= in_data;
            end
            out_valid <= (out_valid & ~pop) | rd_op | bypass;
        end
    end

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl: fixed fill/drain vector table, hand-written corner
// sequences, then random traffic compared against a queue-based FIFO model.
module tb_sp_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       ram_wr;
    logic [2:0] ram_addr;
    logic [3:0] ram_din;
    logic [3:0] ram_dout;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sp_ram_fifo_ctrl #(.DW(4), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .count(count), .full(full), .empty(empty)
    );

    // 8x4 RAM: synchronous write, combinational read
    logic [3:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       ordy;
        logic       ir;
        logic       wr;
        logic [2:0] addr;
        logic       ov;
        logic [3:0] od;
        int         cnt;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic iv, input logic [3:0] d, input logic ordy,
                                input logic ir, input logic wr, input logic [2:0] addr,
                                input logic ov, input logic [3:0] od, input int cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy;
        v.ir = ir; v.wr = wr; v.addr = addr;
        v.ov = ov; v.od = od; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic iv, input logic [3:0] d, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic ov, input logic [3:0] od, input int cnt);
        chk({tag, "_out_valid"}, out_valid, ov);
        if (ov) chk({tag, "_out_data"}, out_data, od);
        chk({tag, "_count"}, count, cnt);
        chk({tag, "_full"}, full, cnt == 9);
        chk({tag, "_empty"}, empty, cnt == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    int q[$];
    int wr_cnt;
    int rd_cnt;

    initial begin
        // bypass, clear, fill to full (10th push held), drain through RAM addr 0..7
        tbl[0]  = mk(1, 4'h7, 1,  1, 0, 0,  1, 4'h7, 1);
        tbl[1]  = mk(0, 4'h0, 1,  1, 0, 0,  0, 4'h0, 0);
        tbl[2]  = mk(1, 4'h7, 0,  1, 0, 0,  1, 4'h7, 1);
        tbl[3]  = mk(1, 4'hE, 0,  1, 1, 0,  1, 4'h7, 2);
        tbl[4]  = mk(1, 4'h2, 0,  1, 1, 1,  1, 4'h7, 3);
        tbl[5]  = mk(1, 4'hC, 0,  1, 1, 2,  1, 4'h7, 4);
        tbl[6]  = mk(1, 4'h3, 0,  1, 1, 3,  1, 4'h7, 5);
        tbl[7]  = mk(1, 4'hA, 0,  1, 1, 4,  1, 4'h7, 6);
        tbl[8]  = mk(1, 4'h7, 0,  1, 1, 5,  1, 4'h7, 7);
        tbl[9]  = mk(1, 4'h5, 0,  1, 1, 6,  1, 4'h7, 8);
        tbl[10] = mk(1, 4'h9, 0,  1, 1, 7,  1, 4'h7, 9);
        tbl[11] = mk(1, 4'hF, 0,  0, 0, 0,  1, 4'h7, 9);
        tbl[12] = mk(0, 4'h0, 1,  0, 0, 0,  1, 4'hE, 8);
        tbl[13] = mk(0, 4'h0, 1,  0, 0, 1,  1, 4'h2, 7);
        tbl[14] = mk(0, 4'h0, 1,  0, 0, 2,  1, 4'hC, 6);
        tbl[15] = mk(0, 4'h0, 1,  0, 0, 3,  1, 4'h3, 5);
        tbl[16] = mk(0, 4'h0, 1,  0, 0, 4,  1, 4'hA, 4);
        tbl[17] = mk(0, 4'h0, 1,  0, 0, 5,  1, 4'h7, 3);
        tbl[18] = mk(0, 4'h0, 1,  0, 0, 6,  1, 4'h5, 2);
        tbl[19] = mk(0, 4'h0, 1,  0, 0, 7,  1, 4'h9, 1);
        tbl[20] = mk(0, 4'h0, 1,  1, 0, 0,  0, 4'h0, 0);

        // reset held with in_valid high
        in_valid = 1'b1;
        in_data  = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("tbl%0d_ram_wr", i), ram_wr, tbl[i].wr);
            chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].addr);
            if (tbl[i].wr) chk($sformatf("tbl%0d_ram_din", i), ram_din, tbl[i].d);
            tick();
            chk_regs($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].od, tbl[i].cnt);
        end

        // single word held, pop and accept together: bypass replaces the output word
        apply(1, 4'h4, 0);
        tick();
        chk_regs("one_a", 1, 4'h4, 1);
        apply(1, 4'h6, 1);
        chk("one_in_ready", in_ready, 1);
        chk("one_ram_wr", ram_wr, 0);
        tick();
        chk_regs("one_b", 1, 4'h6, 1);
        apply(0, 4'h0, 1);
        tick();
        chk_regs("one_c", 0, 4'h0, 0);

        // reset in the middle of a cycle with 5 words stored
        for (int i = 1; i <= 5; i++) begin
            apply(1, 4'(i), 0);
            tick();
        end
        chk("mid_pre_count", count, 5);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_count", count, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_empty", empty, 1);
        chk("mid_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        apply(1, 4'h3, 0);
        chk("mid_push_ram_wr", ram_wr, 0);
        tick();
        chk_regs("mid_push", 1, 4'h3, 1);

        // random traffic against the queue model
        do_reset();
        q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            logic iv, ordy;
            logic [3:0] d;
            int n, ram_words;
            bit pop_e, rd_e, ir_e, acc_e, byp_e, wr_e;
            int addr_e;
            if (c < 150) begin
                iv   = ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 3) == 0);
            end else if (c < 300) begin
                iv   = ($urandom_range(0, 1) != 0);
                ordy = ($urandom_range(0, 1) != 0);
            end else begin
                iv   = ($urandom_range(0, 3) == 0);
                ordy = ($urandom_range(0, 3) != 0);
            end
            d = 4'($urandom);
            apply(iv, d, ordy);

            n         = q.size();
            ram_words = (n > 0) ? n - 1 : 0;
            pop_e     = (n > 0) && ordy;
            rd_e      = pop_e && (ram_words > 0);
            ir_e      = !rd_e && (ram_words != 8);
            acc_e     = iv && ir_e;
            byp_e     = acc_e && (ram_words == 0) && ((n == 0) || pop_e);
            wr_e      = acc_e && !byp_e;
            addr_e    = wr_e ? (wr_cnt % 8) : (rd_cnt % 8);

            chk("rnd_in_ready", in_ready, ir_e);
            chk("rnd_ram_wr", ram_wr, wr_e);
            chk("rnd_ram_addr", ram_addr, addr_e);

            if (pop_e) void'(q.pop_front());
            if (acc_e) q.push_back(int'(d));
            if (wr_e) wr_cnt++;
            if (rd_e) rd_cnt++;

            tick();
            chk_regs("rnd", q.size() > 0, (q.size() > 0) ? 4'(q[0]) : 4'h0, q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
